// File: rtl/pwm_pkg.sv
// Shared widths and constants for the PWM generator.
package pwm_pkg;
   localparam int DUTY_W = 8;
   localparam int PERIOD_TICKS = 255;
   localparam int PRE_W = 16;
   localparam logic [DUTY_W-1:0] DUTY_RESET = 8'hFF;
endpackage

// File: rtl/pwm_dead_time.sv
// Delays the rising edge of one PWM output until its raw high side has been
// stable for DEAD_CYCLES clocks; falling edges pass through with one clock of latency.
module pwm_dead_time #(
   parameter int DEAD_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic raw_in,
   output logic out
);
   localparam logic [7:0] DEAD_MAX = 8'(DEAD_CYCLES);

   logic [7:0] run;

   // run saturates at DEAD_MAX, so DEAD_CYCLES=0 lets the output follow raw_in directly
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run <= 8'd0;
         out <= 1'b0;
      end else if (clr || !raw_in) begin
         run <= 8'd0;
         out <= 1'b0;
      end else begin
         if (run != DEAD_MAX) begin
            run <= run + 8'd1;
         end
         out <= (run == DEAD_MAX);
      end
   end
endmodule

// File: rtl/pwm_generator.sv
// PWM generator: prescaler, 255-tick period counter, glitch-free shadow duty,
// complementary outputs with dead time and a period-start strobe.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 50,
   parameter int DEAD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_out,
   output logic              pwm_out_n,
   output logic              period_start,
   output logic [DUTY_W-1:0] duty_active
);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD_TICKS - 1);

   logic [PRE_W-1:0]  pre;
   logic [DUTY_W-1:0] cnt;
   logic [DUTY_W-1:0] shadow;
   logic              enable_d;
   logic              tick;
   logic              wrap;
   logic              raw;
   logic              raw_n;

   assign tick  = enable && (pre == PRE_LAST);
   assign wrap  = tick && (cnt == CNT_LAST);
   assign raw   = enable && (cnt < shadow);
   assign raw_n = enable && !raw;

   assign duty_active = shadow;

   // While stopped the shadow tracks duty every clock, so a restart uses the latest value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre          <= '0;
         cnt          <= '0;
         shadow       <= DUTY_RESET;
         enable_d     <= 1'b0;
         period_start <= 1'b0;
      end else begin
         enable_d     <= enable;
         period_start <= wrap || (enable && !enable_d);
         if (!enable) begin
            pre    <= '0;
            cnt    <= '0;
            shadow <= duty;
         end else begin
            pre <= tick ? '0 : pre + PRE_W'(1);
            if (tick) begin
               cnt <= wrap ? '0 : cnt + DUTY_W'(1);
            end
            if (wrap) begin
               shadow <= duty;
            end
         end
      end
   end

   pwm_dead_time #(.DEAD_CYCLES(DEAD_CYCLES)) u_dead_hi (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (!enable),
      .raw_in  (raw),
      .out     (pwm_out)
   );

   pwm_dead_time #(.DEAD_CYCLES(DEAD_CYCLES)) u_dead_lo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (!enable),
      .raw_in  (raw_n),
      .out     (pwm_out_n)
   );
endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: unit A (CLK_DIV=2, DEAD_CYCLES=3) walks the
// duty/enable/reset scenarios, unit B (CLK_DIV=1, DEAD_CYCLES=5) covers short pulses.
module tb_pwm_generator;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [7:0] duty;
   logic       pwm_out, pwm_out_n, period_start;
   logic [7:0] duty_active;
   logic       b_enable;
   logic [7:0] b_duty;
   logic       b_pwm_out, b_pwm_out_n, b_period_start;
   logic [7:0] b_duty_active;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pwm_generator #(.CLK_DIV(2), .DEAD_CYCLES(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .duty         (duty),
      .pwm_out      (pwm_out),
      .pwm_out_n    (pwm_out_n),
      .period_start (period_start),
      .duty_active  (duty_active)
   );

   pwm_generator #(.CLK_DIV(1), .DEAD_CYCLES(5)) dut_b (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (b_enable),
      .duty         (b_duty),
      .pwm_out      (b_pwm_out),
      .pwm_out_n    (b_pwm_out_n),
      .period_start (b_period_start),
      .duty_active  (b_duty_active)
   );

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] d);
      enable = en;
      duty   = d;
   endtask

   task automatic checkOutput(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("[TB] %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic waitStart(output int n);
      n = 0;
      do begin
         stepClk();
         n++;
      end while (!period_start && n < 2000);
   endtask

   // Counts one period window starting at a period_start sample; optionally rewrites duty mid-window
   task automatic measure(input int chg_at, input logic [7:0] chg_val,
                          output int len, output int hi, output int hin, output int both);
      len = 0; hi = 0; hin = 0; both = 0;
      do begin
         hi   += int'(pwm_out);
         hin  += int'(pwm_out_n);
         both += int'(pwm_out && pwm_out_n);
         stepClk();
         len++;
         if (len == chg_at) duty = chg_val;
      end while (!period_start && len < 1200);
   endtask

   initial begin
      int n, len, hi, hin, both;
      int b_hi, b_hin, b_ps;
      reset_n  = 1'b0;
      b_enable = 1'b1;
      b_duty   = 8'd3;
      applyStimulus(1'b0, 8'd7);
      repeat (3) stepClk();
      checkOutput("rst_pwm", pwm_out, 0);
      checkOutput("rst_pwm_n", pwm_out_n, 0);
      checkOutput("rst_period_start", period_start, 0);
      checkOutput("rst_duty_active", duty_active, 255);

      applyStimulus(1'b1, 8'd255);
      reset_n = 1'b1;
      stepClk();
      checkOutput("start_strobe", period_start, 1);
      checkOutput("start_pwm_low", pwm_out, 0);
      stepClk(); stepClk();
      checkOutput("dead_hold", pwm_out, 0);
      stepClk();
      checkOutput("dead_rise", pwm_out, 1);
      waitStart(n);
      checkOutput("first_period_len", n, 506);

      measure(-1, 8'd0, len, hi, hin, both);
      checkOutput("full_len", len, 510);
      checkOutput("full_hi", hi, 510);
      checkOutput("full_hin", hin, 0);

      duty = 8'd128;
      checkOutput("shadow_hold", duty_active, 255);
      measure(-1, 8'd0, len, hi, hin, both);
      checkOutput("shadow_load", duty_active, 128);
      measure(-1, 8'd0, len, hi, hin, both);
      measure(-1, 8'd0, len, hi, hin, both);
      checkOutput("d128_len", len, 510);
      checkOutput("d128_hi", hi, 253);
      checkOutput("d128_hin", hin, 251);
      checkOutput("d128_both", both, 0);

      duty = 8'd200;
      measure(-1, 8'd0, len, hi, hin, both);
      checkOutput("d200_active", duty_active, 200);
      measure(100, 8'd10, len, hi, hin, both);
      checkOutput("midchg_len", len, 510);
      checkOutput("midchg_hi", hi, 397);
      checkOutput("midchg_active", duty_active, 10);
      duty = 8'd0;
      measure(-1, 8'd0, len, hi, hin, both);
      checkOutput("d10_hi", hi, 17);
      checkOutput("d10_hin", hin, 487);
      measure(-1, 8'd0, len, hi, hin, both);
      checkOutput("d0_hi", hi, 0);
      checkOutput("d0_hin", hin, 510);

      repeat (200) stepClk();
      checkOutput("pre_dis_n", pwm_out_n, 1);
      applyStimulus(1'b0, 8'd128);
      stepClk();
      checkOutput("dis_pwm", pwm_out, 0);
      checkOutput("dis_pwm_n", pwm_out_n, 0);
      checkOutput("dis_duty_track", duty_active, 128);
      repeat (3) stepClk();
      checkOutput("dis_no_strobe", period_start, 0);

      reset_n = 1'b0;
      #1;
      checkOutput("async_rst_duty", duty_active, 255);
      checkOutput("async_rst_n", pwm_out_n, 0);
      duty = 8'd0;
      stepClk(); stepClk();
      reset_n = 1'b1;
      stepClk(); stepClk();
      checkOutput("idle_duty_track", duty_active, 0);

      enable = 1'b1;
      stepClk();
      checkOutput("re_strobe", period_start, 1);
      checkOutput("re_n_low", pwm_out_n, 0);
      stepClk(); stepClk();
      checkOutput("re_n_hold", pwm_out_n, 0);
      stepClk();
      checkOutput("re_n_rise", pwm_out_n, 1);
      checkOutput("re_pwm_low", pwm_out, 0);
      waitStart(n);
      checkOutput("re_period_len", n, 506);

      b_hi = 0; b_hin = 0; b_ps = 0;
      for (int i = 0; i < 1020; i++) begin
         b_hi  += int'(b_pwm_out);
         b_hin += int'(b_pwm_out_n);
         b_ps  += int'(b_period_start);
         stepClk();
      end
      checkOutput("short_hi", b_hi, 0);
      checkOutput("short_hin", b_hin, 988);
      checkOutput("short_strobes", b_ps, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
